onehot_seq_gen: RTL and testbench
=================================

Name: onehot_seq_gen

Overview:
Parametrised one-hot Moore sequencer: an N-state ring advances one state per enabled cycle, with runtime-selectable length and direction. Output word comes from a writable per-state output table. Not-one-hot state corruption is detected and recovered. Used as a programmable pattern/phase generator wherever the design needs fixed cyclic control sequences.

Parameters:
N_STATES, 7, number of one-hot states (legal 2..32)
OUT_W, 2, width of per-state output word y
IDX_W, $clog2(N_STATES+1), width of len/index fields (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  advance one state this cycle when high
dir  input  1  0 = forward (idx+1), 1 = reverse (idx-1)
len  input  IDX_W  active ring length; effective length clamped to [2, N_STATES]
wr_en  input  1  output-table write strobe
wr_idx  input  IDX_W  table entry to write
wr_data  input  OUT_W  table entry data
state_oh  output  N_STATES  current one-hot state
state_idx  output  IDX_W  binary index of current state
y  output  OUT_W  table[state_idx], combinational from registered state and table
wrap  output  1  registered; pulses 1 cycle after a step that wrapped the ring
err  output  1  combinational; high while state_oh is not exactly one-hot
err_sticky  output  1  registered; set on any err cycle, cleared only by reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). Reset is sampled on the rising edge of clk and has priority over everything else.
- Reset state (applies mid-run too, effective next edge):
  - state_oh = 1 (index 0); state_idx = 0.
  - All table entries = 0, so y = 0.
  - wrap = 0, err_sticky = 0.
- Effective length: L = min(max(len, 2), N_STATES).
- Step when en=1 and err=0:
  - Forward: idx < L-1 -> idx+1. idx >= L-1 -> 0, and wrap=1 on the next cycle.
  - Reverse: idx == 0 -> L-1, and wrap=1. 0 < idx <= L-1 -> idx-1. idx > L-1 (len shrank mid-run) -> L-1, no wrap.
- en=0: state holds, wrap=0.
- Latency: state_oh, state_idx and y reflect a step one cycle after en is sampled. Changing len or dir takes effect on the next step; no flush is needed.
- Error detection:
  - err = (popcount(state_oh) != 1), evaluated every cycle.
  - When err=1, the next state is index 0 regardless of en, dir and len; wrap=0.
  - err_sticky sets on the same edge.
  - While err=1, state_idx = 0 and y = table[0].
- Table write:
  - wr_en=1 writes table[wr_idx] <= wr_data at the edge.
  - wr_idx >= N_STATES: write ignored.
  - A write to the current (or about-to-be-entered) index is visible on y from the next cycle. Writes and steps proceed in the same cycle independently.
- The table is not cleared by len changes. Entries at index >= L are retained.

Decomposition:
- Package onehot_seq_pkg:
  - idx_width(n) function.
  - dir_e enum (DIR_FWD=1'b0, DIR_REV=1'b1).
  - ONEHOT_RESET_IDX=0 constant.
- Sub-module onehot_decode, parametrised by N_STATES:
  - Combinational one-hot-to-binary conversion producing state_idx.
  - Produces the not-one-hot flag used as err.
  - Instantiated once.
- Top level holds the state register, the next-state logic, the output table array and the wrap/err_sticky flops.

Test Plan:
1. Reset, then en=1, dir=0, len=7, table written to {1,0,0,1,1,0,0} for idx 0..6, run 8 steps -> state_idx 0,1,..,6,0; y 1,0,0,1,1,0,0,1; wrap high exactly once, the cycle after 6->0.
2. Reverse with len=4 from idx 0 -> idx 3,2,1,0,3; wrap pulses after 0->3 and again at the next 0->3 step; len=0 and len=1 behave as len=2 (toggle 0,1 forward).
3. Mid-run length shrink: at idx 5, forward, set len=3 -> next idx 0 with wrap. Repeat at idx 5 reverse -> next idx 2, no wrap.
4. Force state_oh=7'b0010010 for one cycle -> err=1 that cycle; next cycle state_idx=0, err=0, err_sticky=1 until reset; en=0 during the force still recovers to 0.
5. Write table[cur_idx]=2'b11 while en=0 -> y=2'b11 next cycle; wr_idx=7 with N_STATES=7 -> no table change.
6. Assert reset mid-sequence with en=1 and wr_en=1 on the same edge -> next cycle state_idx=0, y=0, wrap=0, err_sticky=0; the write is discarded.

Source files
------------

// File: rtl/onehot_seq_pkg.sv
// onehot_seq_pkg: shared types and helpers
// for the one-hot pattern sequencer.
package onehot_seq_pkg;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  localparam int ONEHOT_RESET_IDX = 0;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: one-hot to binary index,
// plus a flag for any non-one-hot pattern.
module onehot_decode
  import onehot_seq_pkg::*;
#(
  parameter int N_STATES = 7,
  localparam int IDX_W = idx_width(N_STATES)
) (
  input  logic [N_STATES-1:0] state_oh,
  output logic [IDX_W-1:0]    state_idx,
  output logic                err
);

  logic [IDX_W-1:0] ones;
  logic [IDX_W-1:0] acc;

  // IDX_W bits can hold a count up to N_STATES
  always_comb begin
    ones = '0;
    acc  = '0;
    for (int i = 0; i < N_STATES; i++) begin
      ones = ones + IDX_W'(state_oh[i]);
      if (state_oh[i]) acc = acc | IDX_W'(i);
    end
  end

  assign err = (ones != IDX_W'(1));
  assign state_idx = err ? IDX_W'(ONEHOT_RESET_IDX)
                         : acc;

endmodule

// File: rtl/onehot_seq_gen.sv
// onehot_seq_gen: programmable one-hot ring
// sequencer with per-state output table.
module onehot_seq_gen
  import onehot_seq_pkg::*;
#(
  parameter int N_STATES = 7,
  parameter int OUT_W = 2,
  localparam int IDX_W = idx_width(N_STATES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                dir,
  input  logic [IDX_W-1:0]    len,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [OUT_W-1:0]    wr_data,
  output logic [N_STATES-1:0] state_oh,
  output logic [IDX_W-1:0]    state_idx,
  output logic [OUT_W-1:0]    y,
  output logic                wrap,
  output logic                err,
  output logic                err_sticky
);

  localparam logic [IDX_W-1:0] RST_IDX =
    IDX_W'(ONEHOT_RESET_IDX);
  localparam logic [N_STATES-1:0] OH_ONE =
    N_STATES'(1);

  logic [N_STATES-1:0] state_q;
  logic [OUT_W-1:0]    tbl [N_STATES];
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    nxt_idx;
  logic                nxt_wrap;
  int                  l_eff;

  assign state_oh = state_q;

  // decode reads the port net so a corrupted
  // pattern is seen by the next-state logic
  onehot_decode #(
    .N_STATES(N_STATES)
  ) u_dec (
    .state_oh (state_oh),
    .state_idx(state_idx),
    .err      (err)
  );

  assign y = tbl[state_idx];

  always_comb begin
    l_eff = int'(len);
    if (l_eff < 2) l_eff = 2;
    if (l_eff > N_STATES) l_eff = N_STATES;
    last = IDX_W'(l_eff - 1);
  end

  always_comb begin
    nxt_idx  = state_idx;
    nxt_wrap = 1'b0;
    if (err) begin
      nxt_idx = RST_IDX;
    end else if (en) begin
      unique case (dir_e'(dir))
        DIR_FWD: begin
          if (state_idx >= last) begin
            nxt_idx  = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_idx = state_idx + IDX_W'(1);
          end
        end
        DIR_REV: begin
          if (state_idx == '0) begin
            nxt_idx  = last;
            nxt_wrap = 1'b1;
          end else if (state_idx > last) begin
            nxt_idx = last;
          end else begin
            nxt_idx = state_idx - IDX_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OH_ONE << RST_IDX;
      wrap       <= 1'b0;
      err_sticky <= 1'b0;
      for (int i = 0; i < N_STATES; i++)
        tbl[i] <= '0;
    end else begin
      state_q    <= OH_ONE << nxt_idx;
      wrap       <= nxt_wrap;
      err_sticky <= err_sticky | err;
      if (wr_en && int'(wr_idx) < N_STATES)
        tbl[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_onehot_seq_gen.sv
// tb_onehot_seq_gen: vector table, directed
// corner cases and random run vs a model.
module tb_onehot_seq_gen;

  localparam int N = 7;
  localparam int OUT_W = 2;
  localparam int IDX_W = $clog2(N + 1);

  logic             clk;
  logic             reset;
  logic             en;
  logic             dir;
  logic [IDX_W-1:0] len;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [OUT_W-1:0] wr_data;
  logic [N-1:0]     state_oh;
  logic [IDX_W-1:0] state_idx;
  logic [OUT_W-1:0] y;
  logic             wrap;
  logic             err;
  logic             err_sticky;

  onehot_seq_gen #(
    .N_STATES(N),
    .OUT_W   (OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .dir       (dir),
    .len       (len),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .state_oh  (state_oh),
    .state_idx (state_idx),
    .y         (y),
    .wrap      (wrap),
    .err       (err),
    .err_sticky(err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit en;
    bit dir;
    int len;
    bit we;
    int wi;
    int wd;
    int e_idx;
    int e_y;
    bit e_wrap;
  } vec_t;

  vec_t vecs[$];

  int n_cmp = 0;
  int n_bad = 0;

  int m_idx;
  int m_tbl [N];
  bit m_wrap;
  bit m_sticky;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[m_idx] = 1'b1;
    chk({tag, ".idx"}, 32'(state_idx), m_idx);
    chk({tag, ".oh"}, 32'(state_oh), 32'(oh));
    chk({tag, ".y"}, 32'(y), m_tbl[m_idx]);
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".sticky"}, 32'(err_sticky),
        32'(m_sticky));
  endtask

  // reference: ring of L positions, L clamped
  task automatic model(input bit r, input bit e,
                       input bit d, input int l,
                       input bit we, input int wi,
                       input int wd);
    int ll;
    if (r) begin
      m_idx = 0;
      m_wrap = 0;
      m_sticky = 0;
      foreach (m_tbl[i]) m_tbl[i] = 0;
      return;
    end
    if (we && wi < N) m_tbl[wi] = wd;
    m_wrap = 0;
    if (!e) return;
    ll = (l < 2) ? 2 : ((l > N) ? N : l);
    if (!d) begin
      m_wrap = (m_idx >= ll - 1);
      m_idx = m_wrap ? 0 : m_idx + 1;
    end else if (m_idx == 0) begin
      m_idx = ll - 1;
      m_wrap = 1;
    end else if (m_idx > ll - 1) begin
      m_idx = ll - 1;
    end else begin
      m_idx = m_idx - 1;
    end
  endtask

  task automatic cycle(input bit r, input bit e,
                       input bit d, input int l,
                       input bit we, input int wi,
                       input int wd);
    reset = r;
    en = e;
    dir = d;
    len = IDX_W'(l);
    wr_en = we;
    wr_idx = IDX_W'(wi);
    wr_data = OUT_W'(wd);
    @(posedge clk);
    model(r, e, d, l, we, wi, wd);
    @(negedge clk);
    check_all("cyc");
  endtask

  function automatic void add(
    bit e, bit d, int l, bit we, int wi, int wd,
    int ei, int ey, bit ew);
    vec_t v;
    v.en = e;  v.dir = d; v.len = l;
    v.we = we; v.wi = wi; v.wd = wd;
    v.e_idx = ei; v.e_y = ey; v.e_wrap = ew;
    vecs.push_back(v);
  endfunction

  initial begin
    int init_tbl [N];
    init_tbl = '{1, 0, 0, 1, 1, 0, 0};

    for (int i = 0; i < N; i++)
      add(0, 0, 7, 1, i, init_tbl[i], 0, 1, 0);
    add(1, 0, 7, 0, 0, 0, 1, 0, 0);
    add(1, 0, 7, 0, 0, 0, 2, 0, 0);
    add(1, 0, 7, 0, 0, 0, 3, 1, 0);
    add(1, 0, 7, 0, 0, 0, 4, 1, 0);
    add(1, 0, 7, 0, 0, 0, 5, 0, 0);
    add(1, 0, 7, 0, 0, 0, 6, 0, 0);
    add(1, 0, 7, 0, 0, 0, 0, 1, 1);
    add(0, 0, 7, 0, 0, 0, 0, 1, 0);
    add(1, 1, 4, 0, 0, 0, 3, 1, 1);
    add(1, 1, 4, 0, 0, 0, 2, 0, 0);
    add(1, 1, 4, 0, 0, 0, 1, 0, 0);
    add(1, 1, 4, 0, 0, 0, 0, 1, 0);
    add(1, 1, 4, 0, 0, 0, 3, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1, 1);

    reset = 1'b1;
    en = 0; dir = 0; len = '0;
    wr_en = 0; wr_idx = '0; wr_data = '0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("rst.idx", 32'(state_idx), 0);
    chk("rst.y", 32'(y), 0);
    chk("rst.wrap", 32'(wrap), 0);
    chk("rst.sticky", 32'(err_sticky), 0);

    foreach (vecs[k]) begin
      cycle(0, vecs[k].en, vecs[k].dir,
            vecs[k].len, vecs[k].we,
            vecs[k].wi, vecs[k].wd);
      chk("vec.idx", 32'(state_idx), vecs[k].e_idx);
      chk("vec.y", 32'(y), vecs[k].e_y);
      chk("vec.wrap", 32'(wrap),
          32'(vecs[k].e_wrap));
    end

    // shrink len while beyond the new ring
    while (m_idx != 5) cycle(0, 1, 0, 7, 0, 0, 0);
    cycle(0, 1, 0, 3, 0, 0, 0);
    chk("shrink_fwd.idx", 32'(state_idx), 0);
    chk("shrink_fwd.wrap", 32'(wrap), 1);
    while (m_idx != 5) cycle(0, 1, 0, 7, 0, 0, 0);
    cycle(0, 1, 1, 3, 0, 0, 0);
    chk("shrink_rev.idx", 32'(state_idx), 2);
    chk("shrink_rev.wrap", 32'(wrap), 0);

    // corrupted state, with en high then low
    for (int p = 0; p < 2; p++) begin
      cycle(0, 1, 0, 7, 0, 0, 0);
      en = (p == 0);
      force dut.state_oh = 7'b0010010;
      #1;
      chk("force.err", 32'(err), 1);
      chk("force.idx", 32'(state_idx), 0);
      chk("force.y", 32'(y), m_tbl[0]);
      @(posedge clk);
      #1;
      release dut.state_oh;
      m_idx = 0;
      m_wrap = 0;
      m_sticky = 1;
      @(negedge clk);
      check_all("recover");
      chk("recover.sticky", 32'(err_sticky), 1);
    end
    cycle(0, 1, 1, 7, 0, 0, 0);
    chk("sticky_hold", 32'(err_sticky), 1);

    // write current entry while holding
    cycle(0, 0, 0, 7, 1, m_idx, 3);
    chk("wr_cur.y", 32'(y), 3);
    cycle(0, 0, 0, 7, 1, 7, 2);
    chk("wr_oob.y", 32'(y), 3);
    for (int i = 0; i < N; i++)
      cycle(0, 1, 0, 7, 0, 0, 0);

    // reset wins over step and write
    cycle(0, 1, 0, 7, 0, 0, 0);
    cycle(1, 1, 0, 7, 1, 0, 3);
    chk("rst_mid.idx", 32'(state_idx), 0);
    chk("rst_mid.y", 32'(y), 0);
    chk("rst_mid.wrap", 32'(wrap), 0);
    chk("rst_mid.sticky", 32'(err_sticky), 0);

    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(39) == 0),
            ($urandom_range(3) != 0),
            1'($urandom_range(1)),
            int'($urandom_range(7)),
            1'($urandom_range(1)),
            int'($urandom_range(7)),
            int'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
